// File: rtl/regfile_arb_pkg.sv
// Shared types and constants for the two-port register-file arbiter.
// Port ids double as the round-robin "last granted" encoding.
package regfile_arb_pkg;

   localparam int unsigned AW_DEF = 8;
   localparam int unsigned DW_DEF = 16;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_ACC  = 2'd1,
      ST_DONE = 2'd2
   } arb_state_e;

   localparam logic PORT_A = 1'b0;
   localparam logic PORT_B = 1'b1;

   // Lone requester wins; on a tie the port that did not go last wins.
   function automatic logic pick_port(input logic a_req, input logic b_req,
                                      input logic last_gnt);
      if (a_req && b_req) return ~last_gnt;
      else if (a_req)     return PORT_A;
      else                return PORT_B;
   endfunction

endpackage

// File: rtl/regfile_arbiter_if.sv
// Host (A) and serial-slave (B) request/response bundle for the arbiter.
interface regfile_arbiter_if
   import regfile_arb_pkg::*;
#(
   parameter int unsigned AW = AW_DEF,
   parameter int unsigned DW = DW_DEF
) ();

   logic          a_req;
   logic          a_cmd;
   logic [AW-1:0] a_addr;
   logic [DW-1:0] a_wdata;
   logic          a_ack;
   logic [DW-1:0] a_rdata;

   logic          b_req;
   logic          b_cmd;
   logic [AW-1:0] b_addr;
   logic [DW-1:0] b_wdata;
   logic          b_resv;
   logic [AW-1:0] b_resv_addr;
   logic          b_ack;
   logic          b_drop;
   logic [DW-1:0] b_rdata;

   modport master (
      output a_req, a_cmd, a_addr, a_wdata,
      output b_req, b_cmd, b_addr, b_wdata, b_resv, b_resv_addr,
      input  a_ack, a_rdata, b_ack, b_drop, b_rdata
   );

   modport slave (
      input  a_req, a_cmd, a_addr, a_wdata,
      input  b_req, b_cmd, b_addr, b_wdata, b_resv, b_resv_addr,
      output a_ack, a_rdata, b_ack, b_drop, b_rdata
   );

endinterface

// File: rtl/regfile_arbiter_ram_sp.sv
// Single-port synchronous RAM, registered read, no reset on contents.
module regfile_ram_sp
   import regfile_arb_pkg::*;
#(
   parameter int unsigned AW = AW_DEF,
   parameter int unsigned DW = DW_DEF
) (
   input  logic          clk,
   input  logic          we_i,
   input  logic [AW-1:0] addr_i,
   input  logic [DW-1:0] wdata_i,
   output logic [DW-1:0] rdata_o
);

   localparam int unsigned DEPTH = 1 << AW;

   logic [DW-1:0] mem_q [DEPTH];

   always_ff @(posedge clk) begin
      if (we_i) mem_q[addr_i] <= wdata_i;
      rdata_o <= mem_q[addr_i];
   end

endmodule

// File: rtl/regfile_arbiter.sv
// Round-robin arbiter sharing one register file between host (A) and serial (B)
// ports, with host-write-wins coherence against open serial reservations.
module regfile_arbiter
   import regfile_arb_pkg::*;
#(
   parameter int unsigned AW = AW_DEF,
   parameter int unsigned DW = DW_DEF
) (
   input  logic             clk,
   input  logic             reset_n,
   regfile_arbiter_if.slave bus
);

   arb_state_e    state_q;
   logic          last_gnt_q;
   logic          port_q;
   logic          cmd_q;
   logic [AW-1:0] addr_q;
   logic [DW-1:0] wdata_q;
   logic          a_ack_q;
   logic          b_ack_q;
   logic          b_drop_q;
   logic [DW-1:0] a_rdata_q;
   logic [DW-1:0] b_rdata_q;
   logic          conf_flag_q;
   logic [AW-1:0] conf_addr_q;

   logic          win_c;
   logic [AW-1:0] ram_addr_c;
   logic          ram_we_c;
   logic          conf_set_c;
   logic          drop_c;
   logic [DW-1:0] ram_rdata;

   assign win_c = pick_port(bus.a_req, bus.b_req, last_gnt_q);

   // Reads are issued from IDLE so data is ready in ACC; writes land in ACC.
   assign ram_addr_c = (state_q == ST_IDLE)
                       ? ((win_c == PORT_A) ? bus.a_addr : bus.b_addr)
                       : addr_q;

   assign conf_set_c = (state_q == ST_ACC) && (port_q == PORT_A) && cmd_q &&
                       bus.b_resv && (addr_q == bus.b_resv_addr);

   assign drop_c     = (state_q == ST_ACC) && (port_q == PORT_B) && cmd_q &&
                       conf_flag_q && (addr_q == conf_addr_q);

   assign ram_we_c   = (state_q == ST_ACC) && cmd_q && !drop_c;

   regfile_ram_sp #(.AW(AW), .DW(DW)) u_ram (
      .clk     (clk),
      .we_i    (ram_we_c),
      .addr_i  (ram_addr_c),
      .wdata_i (wdata_q),
      .rdata_o (ram_rdata)
   );

   // Access sequencer: IDLE grants, ACC performs, DONE carries the ack.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= ST_IDLE;
         last_gnt_q <= PORT_B;
         port_q     <= PORT_A;
         cmd_q      <= 1'b0;
         addr_q     <= '0;
         wdata_q    <= '0;
         a_ack_q    <= 1'b0;
         b_ack_q    <= 1'b0;
         b_drop_q   <= 1'b0;
         a_rdata_q  <= '0;
         b_rdata_q  <= '0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (bus.a_req || bus.b_req) begin
                  port_q  <= win_c;
                  cmd_q   <= (win_c == PORT_A) ? bus.a_cmd   : bus.b_cmd;
                  addr_q  <= (win_c == PORT_A) ? bus.a_addr  : bus.b_addr;
                  wdata_q <= (win_c == PORT_A) ? bus.a_wdata : bus.b_wdata;
                  state_q <= ST_ACC;
               end
            end
            ST_ACC: begin
               if (port_q == PORT_A) begin
                  a_ack_q <= 1'b1;
                  if (!cmd_q) a_rdata_q <= ram_rdata;
               end else begin
                  b_ack_q  <= 1'b1;
                  b_drop_q <= drop_c;
                  if (!cmd_q) b_rdata_q <= ram_rdata;
               end
               last_gnt_q <= port_q;
               state_q    <= ST_DONE;
            end
            ST_DONE: begin
               a_ack_q  <= 1'b0;
               b_ack_q  <= 1'b0;
               b_drop_q <= 1'b0;
               state_q  <= ST_IDLE;
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   // Conflict tracker; a fresh host hit takes priority over any clear.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         conf_flag_q <= 1'b0;
         conf_addr_q <= '0;
      end else if (conf_set_c) begin
         conf_flag_q <= 1'b1;
         conf_addr_q <= addr_q;
      end else if (b_ack_q || !bus.b_resv) begin
         conf_flag_q <= 1'b0;
      end
   end

   assign bus.a_ack   = a_ack_q;
   assign bus.a_rdata = a_rdata_q;
   assign bus.b_ack   = b_ack_q;
   assign bus.b_drop  = b_drop_q;
   assign bus.b_rdata = b_rdata_q;

endmodule

// File: tb/tb_regfile_arbiter.sv
// Bench for regfile_arbiter: directed vector table, round-robin and reset
// sequences, then random traffic against a transaction-level model.
module tb_regfile_arbiter;

   logic clk;
   logic reset_n;
   int   errors;
   int   checks;

   regfile_arbiter_if #(.AW(8), .DW(16)) bus ();

   regfile_arbiter #(.AW(8), .DW(16)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      bit          rst;
      bit          ae;
      bit          ac;
      logic [7:0]  aa;
      logic [15:0] aw;
      bit          be;
      bit          bc;
      logic [7:0]  ba;
      logic [15:0] bw;
      bit          rs;
      logic [7:0]  ra;
      int          ea;
      int          eb;
      logic [15:0] ard;
      logic [15:0] brd;
      bit          dr;
   } vec_t;

   vec_t vecs[$];

   // Transaction-level reference state
   logic [15:0] m_mem   [256];
   bit          m_valid [256];
   bit          m_last;
   bit          m_flag;
   logic [7:0]  m_conf;

   function automatic vec_t mkv(bit rst, bit ae, bit ac, logic [7:0] aa, logic [15:0] aw,
                                bit be, bit bc, logic [7:0] ba, logic [15:0] bw,
                                bit rs, logic [7:0] ra, int ea, int eb,
                                logic [15:0] ard, logic [15:0] brd, bit dr);
      vec_t v;
      v.rst = rst; v.ae = ae; v.ac = ac; v.aa = aa; v.aw = aw;
      v.be = be; v.bc = bc; v.ba = ba; v.bw = bw; v.rs = rs; v.ra = ra;
      v.ea = ea; v.eb = eb; v.ard = ard; v.brd = brd; v.dr = dr;
      return v;
   endfunction

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic do_reset();
      bus.a_req = 1'b0;
      bus.b_req = 1'b0;
      reset_n   = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk) reset_n = 1'b1;
      @(posedge clk);
      #1;
   endtask

   task automatic model_reset();
      for (int i = 0; i < 256; i++) m_valid[i] = 1'b0;
      m_last = 1'b1;
      m_flag = 1'b0;
      m_conf = 8'h00;
   endtask

   // One granted transaction, applied in grant order.
   task automatic m_txn(input bit port, input bit cmd, input logic [7:0] addr,
                        input logic [15:0] wd, input bit resv, input logic [7:0] raddr,
                        output logic [15:0] rd, output bit rd_ok, output bit drop);
      rd = 16'h0; rd_ok = 1'b0; drop = 1'b0;
      if (!resv) m_flag = 1'b0;
      if (cmd) begin
         if (port && m_flag && addr == m_conf) drop = 1'b1;
         else begin
            m_mem[addr]   = wd;
            m_valid[addr] = 1'b1;
         end
         if (!port && resv && addr == raddr) begin
            m_flag = 1'b1;
            m_conf = addr;
         end
      end else begin
         rd    = m_mem[addr];
         rd_ok = m_valid[addr];
      end
      if (port) m_flag = 1'b0;
      m_last = port;
   endtask

   // Drive one or two requests from an idle start; watch a fixed 9-cycle window.
   task automatic run(input bit ae, input bit ac, input logic [7:0] aa, input logic [15:0] aw,
                      input bit be, input bit bc, input logic [7:0] ba, input logic [15:0] bw,
                      input bit rs, input logic [7:0] ra,
                      output int a_cyc, output int b_cyc,
                      output logic [15:0] a_rd, output logic [15:0] b_rd, output bit drop);
      a_cyc = -1; b_cyc = -1; a_rd = 16'h0; b_rd = 16'h0; drop = 1'b0;
      bus.b_resv = rs;  bus.b_resv_addr = ra;
      bus.a_req  = ae;  bus.a_cmd = ac; bus.a_addr = aa; bus.a_wdata = aw;
      bus.b_req  = be;  bus.b_cmd = bc; bus.b_addr = ba; bus.b_wdata = bw;
      for (int cyc = 0; cyc < 9; cyc++) begin
         @(negedge clk);
         if (bus.a_ack) begin
            a_cyc = cyc; a_rd = bus.a_rdata; bus.a_req = 1'b0;
         end
         if (bus.b_ack) begin
            b_cyc = cyc; b_rd = bus.b_rdata; drop = bus.b_drop; bus.b_req = 1'b0;
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic table_phase();
      int a_cyc, b_cyc;
      logic [15:0] a_rd, b_rd;
      bit drop;
      vec_t v;
      vecs.push_back(mkv(0, 1,1,8'h12,16'hBEEF, 0,0,8'h00,16'h0000, 0,8'h00,  2,-1,16'h0000,16'h0000,0));
      vecs.push_back(mkv(0, 1,0,8'h12,16'h0000, 0,0,8'h00,16'h0000, 0,8'h00,  2,-1,16'hBEEF,16'h0000,0));
      vecs.push_back(mkv(0, 1,1,8'h01,16'h0A01, 0,0,8'h00,16'h0000, 0,8'h00,  2,-1,16'h0000,16'h0000,0));
      vecs.push_back(mkv(0, 0,0,8'h00,16'h0000, 1,1,8'h02,16'h0B02, 0,8'h00, -1, 2,16'h0000,16'h0000,0));
      vecs.push_back(mkv(1, 1,0,8'h01,16'h0000, 1,0,8'h02,16'h0000, 0,8'h00,  2, 5,16'h0A01,16'h0B02,0));
      vecs.push_back(mkv(0, 1,0,8'h02,16'h0000, 1,0,8'h01,16'h0000, 0,8'h00,  2, 5,16'h0B02,16'h0A01,0));
      vecs.push_back(mkv(0, 1,1,8'h40,16'h1111, 0,0,8'h00,16'h0000, 1,8'h40,  2,-1,16'h0000,16'h0000,0));
      vecs.push_back(mkv(0, 0,0,8'h00,16'h0000, 1,1,8'h40,16'h2222, 1,8'h40, -1, 2,16'h0000,16'h0000,1));
      vecs.push_back(mkv(0, 1,0,8'h40,16'h0000, 0,0,8'h00,16'h0000, 1,8'h40,  2,-1,16'h1111,16'h0000,0));
      vecs.push_back(mkv(0, 0,0,8'h00,16'h0000, 1,1,8'h40,16'h5555, 1,8'h40, -1, 2,16'h0000,16'h0000,0));
      vecs.push_back(mkv(0, 1,0,8'h40,16'h0000, 0,0,8'h00,16'h0000, 1,8'h40,  2,-1,16'h5555,16'h0000,0));
      vecs.push_back(mkv(0, 1,1,8'h40,16'h1111, 0,0,8'h00,16'h0000, 1,8'h40,  2,-1,16'h0000,16'h0000,0));
      vecs.push_back(mkv(0, 0,0,8'h00,16'h0000, 1,1,8'h41,16'h2222, 1,8'h40, -1, 2,16'h0000,16'h0000,0));
      vecs.push_back(mkv(0, 1,0,8'h41,16'h0000, 0,0,8'h00,16'h0000, 1,8'h40,  2,-1,16'h2222,16'h0000,0));
      vecs.push_back(mkv(0, 1,1,8'h40,16'h7777, 0,0,8'h00,16'h0000, 0,8'h40,  2,-1,16'h0000,16'h0000,0));
      vecs.push_back(mkv(0, 0,0,8'h00,16'h0000, 1,1,8'h40,16'h2222, 0,8'h40, -1, 2,16'h0000,16'h0000,0));
      vecs.push_back(mkv(0, 1,0,8'h40,16'h0000, 0,0,8'h00,16'h0000, 0,8'h40,  2,-1,16'h2222,16'h0000,0));
      vecs.push_back(mkv(0, 1,1,8'h40,16'h1234, 0,0,8'h00,16'h0000, 1,8'h40,  2,-1,16'h0000,16'h0000,0));
      vecs.push_back(mkv(0, 0,0,8'h00,16'h0000, 1,1,8'h40,16'h3333, 0,8'h40, -1, 2,16'h0000,16'h0000,0));
      vecs.push_back(mkv(0, 1,0,8'h40,16'h0000, 0,0,8'h00,16'h0000, 0,8'h40,  2,-1,16'h3333,16'h0000,0));
      vecs.push_back(mkv(0, 1,1,8'h40,16'h4444, 0,0,8'h00,16'h0000, 0,8'h40,  2,-1,16'h0000,16'h0000,0));
      vecs.push_back(mkv(0, 0,0,8'h00,16'h0000, 1,1,8'h40,16'h6666, 1,8'h40, -1, 2,16'h0000,16'h0000,0));
      vecs.push_back(mkv(0, 0,0,8'h00,16'h0000, 1,0,8'h40,16'h0000, 1,8'h40, -1, 2,16'h0000,16'h6666,0));
      vecs.push_back(mkv(0, 1,1,8'h40,16'h9999, 0,0,8'h00,16'h0000, 1,8'h40,  2,-1,16'h0000,16'h0000,0));
      vecs.push_back(mkv(0, 0,0,8'h00,16'h0000, 1,0,8'h40,16'h0000, 1,8'h40, -1, 2,16'h0000,16'h9999,0));
      vecs.push_back(mkv(0, 1,1,8'h50,16'hAAAA, 1,1,8'h50,16'hBBBB, 1,8'h50,  2, 5,16'h0000,16'h0000,1));
      vecs.push_back(mkv(0, 1,0,8'h50,16'h0000, 0,0,8'h00,16'h0000, 1,8'h50,  2,-1,16'hAAAA,16'h0000,0));
      for (int i = 0; i < vecs.size(); i++) begin
         v = vecs[i];
         if (v.rst) do_reset();
         run(v.ae, v.ac, v.aa, v.aw, v.be, v.bc, v.ba, v.bw, v.rs, v.ra,
             a_cyc, b_cyc, a_rd, b_rd, drop);
         check($sformatf("v%0d a_ack cycle", i), 32'(a_cyc), 32'(v.ea));
         check($sformatf("v%0d b_ack cycle", i), 32'(b_cyc), 32'(v.eb));
         if (v.ae && !v.ac) check($sformatf("v%0d a_rdata", i), 32'(a_rd), 32'(v.ard));
         if (v.be && !v.bc) check($sformatf("v%0d b_rdata", i), 32'(b_rd), 32'(v.brd));
         if (v.be)          check($sformatf("v%0d b_drop", i), 32'(drop), 32'(v.dr));
      end
   endtask

   // A re-requests straight after its ack while B waits: B must go next.
   task automatic round_robin_seq();
      int a1, a2, bc;
      logic [15:0] ard1, ard2, brd;
      a1 = -1; a2 = -1; bc = -1; ard1 = 16'h0; ard2 = 16'h0; brd = 16'h0;
      do_reset();
      bus.b_resv = 1'b0;
      bus.a_req = 1'b1; bus.a_cmd = 1'b0; bus.a_addr = 8'h01;
      bus.b_req = 1'b1; bus.b_cmd = 1'b0; bus.b_addr = 8'h02;
      for (int cyc = 0; cyc < 12; cyc++) begin
         @(negedge clk);
         if (bus.a_ack) begin
            if (a1 < 0) begin
               a1 = cyc; ard1 = bus.a_rdata; bus.a_addr = 8'h12;
            end else begin
               a2 = cyc; ard2 = bus.a_rdata; bus.a_req = 1'b0;
            end
         end
         if (bus.b_ack) begin
            bc = cyc; brd = bus.b_rdata; bus.b_req = 1'b0;
         end
      end
      check("rr first a cycle", 32'(a1), 32'd2);
      check("rr first a rdata", 32'(ard1), 32'h0A01);
      check("rr b cycle", 32'(bc), 32'd5);
      check("rr b rdata", 32'(brd), 32'h0B02);
      check("rr second a cycle", 32'(a2), 32'd8);
      check("rr second a rdata", 32'(ard2), 32'hBEEF);
      check("rdata hold ack", 32'(bus.a_ack), 32'd0);
      check("rdata hold value", 32'(bus.a_rdata), 32'hBEEF);
      @(posedge clk);
      #1;
   endtask

   task automatic random_phase();
      int a_cyc, b_cyc, ea, eb;
      logic [15:0] a_rd, b_rd, erda, erdb, rd;
      bit drop, ed, oka, okb, ok, dr, ae, be, ac, bc, rs, a_first;
      logic [7:0] aa, ba, ra;
      logic [15:0] aw, bw;
      do_reset();
      model_reset();
      for (int n = 0; n < 80; n++) begin
         ae = 1'($urandom_range(0, 1));
         be = 1'($urandom_range(0, 1));
         if (!ae && !be) ae = 1'b1;
         ac = 1'($urandom_range(0, 1));
         bc = 1'($urandom_range(0, 1));
         aa = 8'(8'h60 + 8'($urandom_range(0, 3)));
         ba = 8'(8'h60 + 8'($urandom_range(0, 3)));
         aw = 16'($urandom);
         bw = 16'($urandom);
         rs = ($urandom_range(0, 3) != 0);
         ra = 8'(8'h60 + 8'($urandom_range(0, 3)));
         ea = -1; eb = -1; erda = 16'h0; erdb = 16'h0; ed = 1'b0; oka = 1'b0; okb = 1'b0;
         a_first = ae && (!be || m_last);
         if (a_first) begin
            m_txn(1'b0, ac, aa, aw, rs, ra, erda, oka, dr);
            ea = 2;
            if (be) begin
               m_txn(1'b1, bc, ba, bw, rs, ra, erdb, okb, ed);
               eb = 5;
            end
         end else begin
            m_txn(1'b1, bc, ba, bw, rs, ra, erdb, okb, ed);
            eb = 2;
            if (ae) begin
               m_txn(1'b0, ac, aa, aw, rs, ra, erda, oka, dr);
               ea = 5;
            end
         end
         run(ae, ac, aa, aw, be, bc, ba, bw, rs, ra, a_cyc, b_cyc, a_rd, b_rd, drop);
         check($sformatf("r%0d a_ack cycle", n), 32'(a_cyc), 32'(ea));
         check($sformatf("r%0d b_ack cycle", n), 32'(b_cyc), 32'(eb));
         if (ae && !ac && oka) check($sformatf("r%0d a_rdata", n), 32'(a_rd), 32'(erda));
         if (be && !bc && okb) check($sformatf("r%0d b_rdata", n), 32'(b_rd), 32'(erdb));
         if (be) check($sformatf("r%0d b_drop", n), 32'(drop), 32'(ed));
      end
      ok = 1'b1; rd = 16'h0;
      if (ok) rd = 16'h0;
   endtask

   // Reset lands during ACC of a host write: no ack, cleared outputs, clean restart.
   task automatic reset_mid_acc_seq();
      int a_cyc, b_cyc;
      logic [15:0] a_rd, b_rd;
      bit drop, seen;
      bus.b_resv = 1'b0;
      bus.a_req = 1'b1; bus.a_cmd = 1'b1; bus.a_addr = 8'h70; bus.a_wdata = 16'hDEAD;
      @(negedge clk);
      @(negedge clk);
      reset_n = 1'b0;
      bus.a_req = 1'b0;
      #1;
      check("rst a_ack", 32'(bus.a_ack), 32'd0);
      check("rst b_ack", 32'(bus.b_ack), 32'd0);
      check("rst b_drop", 32'(bus.b_drop), 32'd0);
      check("rst a_rdata", 32'(bus.a_rdata), 32'd0);
      check("rst b_rdata", 32'(bus.b_rdata), 32'd0);
      seen = 1'b0;
      repeat (3) begin
         @(negedge clk);
         if (bus.a_ack) seen = 1'b1;
      end
      check("rst no a_ack", 32'(seen), 32'd0);
      reset_n = 1'b1;
      @(posedge clk);
      #1;
      run(1'b0, 1'b0, 8'h00, 16'h0, 1'b1, 1'b0, 8'h12, 16'h0, 1'b0, 8'h00,
          a_cyc, b_cyc, a_rd, b_rd, drop);
      check("post-rst a_ack cycle", 32'(a_cyc), -32'sd1);
      check("post-rst b_ack cycle", 32'(b_cyc), 32'd2);
      check("post-rst b_rdata", 32'(b_rd), 32'hBEEF);
   endtask

   initial begin
      errors = 0;
      checks = 0;
      reset_n = 1'b0;
      bus.a_req = 1'b0; bus.a_cmd = 1'b0; bus.a_addr = 8'h0; bus.a_wdata = 16'h0;
      bus.b_req = 1'b0; bus.b_cmd = 1'b0; bus.b_addr = 8'h0; bus.b_wdata = 16'h0;
      bus.b_resv = 1'b0; bus.b_resv_addr = 8'h0;
      do_reset();
      check("reset a_ack", 32'(bus.a_ack), 32'd0);
      check("reset b_ack", 32'(bus.b_ack), 32'd0);
      check("reset b_drop", 32'(bus.b_drop), 32'd0);
      check("reset a_rdata", 32'(bus.a_rdata), 32'd0);
      check("reset b_rdata", 32'(bus.b_rdata), 32'd0);
      table_phase();
      round_robin_seq();
      random_phase();
      reset_mid_acc_seq();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
